bnn_accum_binarize: RTL and testbench
=====================================

BNN_ACCUM_BINARIZE -- requirements
Module: bnn_accum_binarize

Consumes per-PE popcount vectors from pe_array, accumulates them across the words of one dot product, thresholds the sums, and emits one binary activation bit per PE.

Interface
REQ-001 Parameter NUM_PES, default 64: number of PE lanes, one popcount per lane per beat.
REQ-002 Parameter WORD_SIZE, default 64: bits per PE word; PCW = $clog2(WORD_SIZE+1) (default 7).
REQ-003 Parameter ACCW, default 12: accumulator width per lane, unsigned.
REQ-004 Parameter MAX_BEATS, default 64: maximum words per dot product; BCW = $clog2(MAX_BEATS+1).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  popcount beat valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_last  input  1  beat is the final word of the current dot product.
REQ-010 popcounts_in_flat  input  NUM_PES*PCW  lane p at bits [p*PCW +: PCW].
REQ-011 threshold_flat  input  NUM_PES*ACCW  per-lane threshold, sampled only on the closing beat.
REQ-012 out_valid  output  1  result registers hold an unconsumed result.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 act_out  output  NUM_PES  bit p = 1 iff lane p sum >= lane p threshold.
REQ-015 acc_out_flat  output  NUM_PES*ACCW  final saturated lane sums.
REQ-016 out_beats  output  BCW  number of beats in the reported dot product (1..MAX_BEATS).
REQ-017 out_ovf  output  1  at least one lane saturated during the reported dot product.
REQ-018 out_forced  output  1  the dot product was closed by the MAX_BEATS limit, not by in_last.

Function
REQ-019 A beat is accepted when in_valid && in_ready.
REQ-020 in_ready = rst_n && (!out_valid || out_ready), combinational, so a result may drain and a new beat be accepted in the same cycle.
REQ-021 Internal state: ACCUM (beat_cnt == 0 or > 0) plus an output-register-full flag (out_valid); no other states.
REQ-022 Non-closing accepted beat: acc[p] <= sat(acc[p] + pc[p]) for every lane; beat_cnt += 1; a lane that saturates sets the sticky ovf flag.
REQ-023 sat() clamps to 2^ACCW-1. PCW-bit popcounts are zero-extended before the add.
REQ-024 Closing beat: an accepted beat with in_last = 1, or with beat_cnt == MAX_BEATS-1.
REQ-025 On a closing beat, the next edge loads:
  - acc_out = sat(acc + pc)
  - act_out[p] = (acc_out[p] >= thr[p])
  - out_beats = beat_cnt + 1
  - out_ovf = ovf OR saturation on this beat
  - out_forced = !in_last
  - out_valid = 1
REQ-026 The same edge clears acc, beat_cnt and ovf to 0. Latency from closing beat to out_valid is 1 cycle.
REQ-027 If out_valid && out_ready with no closing beat, out_valid <= 0 next edge. Output data then holds its last value.
REQ-028 While out_valid && !out_ready, all output signals are held stable and no beat is accepted.
REQ-029 Beats presented with in_valid = 0 or in_ready = 0 do not change any state. Popcount inputs are don't-care when not accepted.
REQ-030 A threshold of 0 makes the lane bit 1. A threshold above 2^ACCW-1 is unrepresentable by construction.

Reset
REQ-031 While rst_n = 0 at a rising edge, the following clear to 0: acc, beat_cnt, ovf, out_valid, act_out, acc_out_flat, out_beats, out_ovf and out_forced.
REQ-032 While rst_n = 0, in_ready = 0.
REQ-033 A reset asserted mid-dot-product discards the partial sums with no output. The first beat accepted after reset starts a new dot product.

Verification
REQ-034 Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> in_ready = 0 and all outputs 0; after release, in_ready = 1.
REQ-035 Single beat, in_last = 1, lane0 pc = 28 with thr = 28, lane63 pc = 0 with thr = 1, out_ready = 1:
  - next cycle: out_valid = 1, act_out[0] = 1, act_out[63] = 0, acc_out lane0 = 28, out_beats = 1, out_ovf = 0, out_forced = 0.
REQ-036 Three beats, lane5 pc = 10, 20, 30, last on the third, thr = 61 -> acc_out lane5 = 60, act_out[5] = 0, out_beats = 3.
  - Repeat with thr = 60 -> act_out[5] = 1.
REQ-037 Backpressure:
  - result pending, out_ready = 0 for 4 cycles -> in_ready = 0 and outputs unchanged.
  - then out_ready = 1 together with a closing beat (pc = 7) -> that beat is accepted and the next cycle shows acc_out = 7 with out_valid still 1.
REQ-038 64 beats, all lanes pc = 64, in_last never asserted -> after beat 64: acc_out = 4095 (saturated from 4096), out_ovf = 1, out_forced = 1, out_beats = 64. The next dot product starts from 0.
REQ-039 Reset mid-product: 2 beats of pc = 40, reset for 1 cycle, then 1 beat pc = 3 with in_last -> acc_out = 3, out_beats = 1.

Source files
------------

// File: rtl/bnn_accum_binarize.sv
//==============================================================================
// Module      : bnn_accum_binarize
// Description : Accumulates per-PE popcounts over one dot product, thresholds
//               the saturated sums and emits one activation bit per PE.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bnn_accum_binarize #(
    parameter int NUM_PES   = 64,
    parameter int WORD_SIZE = 64,
    parameter int ACCW      = 12,
    parameter int MAX_BEATS = 64,
    localparam int PCW      = $clog2(WORD_SIZE + 1),
    localparam int BCW      = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [NUM_PES*PCW-1:0]  popcounts_in_flat,
    input  logic [NUM_PES*ACCW-1:0] threshold_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_PES-1:0]      act_out,
    output logic [NUM_PES*ACCW-1:0] acc_out_flat,
    output logic [BCW-1:0]          out_beats,
    output logic                    out_ovf,
    output logic                    out_forced
);

    localparam int              C_EXTW    = ACCW + 1;
    localparam logic [ACCW-1:0] C_ACC_MAX = '1;
    localparam logic [BCW-1:0]  C_LAST_CNT = BCW'(MAX_BEATS - 1);

    logic [NUM_PES*ACCW-1:0] r_acc_q,        w_acc_d;
    logic [BCW-1:0]          r_beat_cnt_q,   w_beat_cnt_d;
    logic                    r_ovf_q,        w_ovf_d;
    logic                    r_out_valid_q,  w_out_valid_d;
    logic [NUM_PES-1:0]      r_act_q,        w_act_d;
    logic [NUM_PES*ACCW-1:0] r_acc_out_q,    w_acc_out_d;
    logic [BCW-1:0]          r_out_beats_q,  w_out_beats_d;
    logic                    r_out_ovf_q,    w_out_ovf_d;
    logic                    r_out_forced_q, w_out_forced_d;

    logic [NUM_PES*ACCW-1:0] w_sum_flat;
    logic [NUM_PES-1:0]      w_lane_sat;
    logic [NUM_PES-1:0]      w_lane_act;
    logic                    w_accept;
    logic                    w_closing;
    logic                    w_any_sat;

    // One extra bit of headroom per lane exposes the carry used for clamping.
    generate
        for (genvar p = 0; p < NUM_PES; p++) begin : g_lane
            logic [C_EXTW-1:0] w_raw;
            assign w_raw = {1'b0, r_acc_q[p*ACCW +: ACCW]}
                         + C_EXTW'(popcounts_in_flat[p*PCW +: PCW]);
            assign w_lane_sat[p]              = w_raw[ACCW];
            assign w_sum_flat[p*ACCW +: ACCW] = w_raw[ACCW] ? C_ACC_MAX : w_raw[ACCW-1:0];
            assign w_lane_act[p] = (w_sum_flat[p*ACCW +: ACCW] >= threshold_flat[p*ACCW +: ACCW]);
        end
    endgenerate

    assign in_ready  = rst_n && (!r_out_valid_q || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_closing = w_accept && (in_last || (r_beat_cnt_q == C_LAST_CNT));
    assign w_any_sat = |w_lane_sat;

    always_comb begin
        w_acc_d        = r_acc_q;
        w_beat_cnt_d   = r_beat_cnt_q;
        w_ovf_d        = r_ovf_q;
        w_out_valid_d  = r_out_valid_q;
        w_act_d        = r_act_q;
        w_acc_out_d    = r_acc_out_q;
        w_out_beats_d  = r_out_beats_q;
        w_out_ovf_d    = r_out_ovf_q;
        w_out_forced_d = r_out_forced_q;

        // Drain first; a closing beat in the same cycle re-arms the result.
        if (r_out_valid_q && out_ready) begin
            w_out_valid_d = 1'b0;
        end

        if (w_closing) begin
            w_acc_out_d    = w_sum_flat;
            w_act_d        = w_lane_act;
            w_out_beats_d  = r_beat_cnt_q + BCW'(1);
            w_out_ovf_d    = r_ovf_q || w_any_sat;
            w_out_forced_d = !in_last;
            w_out_valid_d  = 1'b1;
            w_acc_d        = '0;
            w_beat_cnt_d   = '0;
            w_ovf_d        = 1'b0;
        end else if (w_accept) begin
            w_acc_d      = w_sum_flat;
            w_beat_cnt_d = r_beat_cnt_q + BCW'(1);
            w_ovf_d      = r_ovf_q || w_any_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_q        <= '0;
            r_beat_cnt_q   <= '0;
            r_ovf_q        <= 1'b0;
            r_out_valid_q  <= 1'b0;
            r_act_q        <= '0;
            r_acc_out_q    <= '0;
            r_out_beats_q  <= '0;
            r_out_ovf_q    <= 1'b0;
            r_out_forced_q <= 1'b0;
        end else begin
            r_acc_q        <= w_acc_d;
            r_beat_cnt_q   <= w_beat_cnt_d;
            r_ovf_q        <= w_ovf_d;
            r_out_valid_q  <= w_out_valid_d;
            r_act_q        <= w_act_d;
            r_acc_out_q    <= w_acc_out_d;
            r_out_beats_q  <= w_out_beats_d;
            r_out_ovf_q    <= w_out_ovf_d;
            r_out_forced_q <= w_out_forced_d;
        end
    end

    assign out_valid    = r_out_valid_q;
    assign act_out      = r_act_q;
    assign acc_out_flat = r_acc_out_q;
    assign out_beats    = r_out_beats_q;
    assign out_ovf      = r_out_ovf_q;
    assign out_forced   = r_out_forced_q;

endmodule

`default_nettype wire

// File: tb/tb_bnn_accum_binarize.sv
//==============================================================================
// Module      : tb_bnn_accum_binarize
// Description : Directed self-checking bench for bnn_accum_binarize.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bnn_accum_binarize;

    localparam int NP   = 64;
    localparam int PCW  = 7;
    localparam int ACCW = 12;
    localparam int BCW  = 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [NP*PCW-1:0]  pc_flat;
    logic [NP*ACCW-1:0] thr_flat;
    logic               out_valid;
    logic               out_ready;
    logic [NP-1:0]      act_out;
    logic [NP*ACCW-1:0] acc_out_flat;
    logic [BCW-1:0]     out_beats;
    logic               out_ovf;
    logic               out_forced;

    int checks = 0;
    int errors = 0;

    bnn_accum_binarize #(
        .NUM_PES   (NP),
        .WORD_SIZE (64),
        .ACCW      (ACCW),
        .MAX_BEATS (64)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_last           (in_last),
        .popcounts_in_flat (pc_flat),
        .threshold_flat    (thr_flat),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .act_out           (act_out),
        .acc_out_flat      (acc_out_flat),
        .out_beats         (out_beats),
        .out_ovf           (out_ovf),
        .out_forced        (out_forced)
    );

    always #5 clk = ~clk;

    function automatic int lane_acc(input int p);
        return int'(acc_out_flat[p*ACCW +: ACCW]);
    endfunction

    task automatic set_all_pc(input int v);
        for (int p = 0; p < NP; p++) pc_flat[p*PCW +: PCW] = PCW'(v);
    endtask

    task automatic set_all_thr(input int v);
        for (int p = 0; p < NP; p++) thr_flat[p*ACCW +: ACCW] = ACCW'(v);
    endtask

    // Present one beat for exactly one edge; inputs change 1 time unit after edges.
    task automatic send_beat(input logic last);
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        set_all_pc(5); set_all_thr(0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (act_out !== '0) begin errors++; $display("FAIL reset_act got %h exp 0", act_out); end
        checks++; if (acc_out_flat !== '0) begin errors++; $display("FAIL reset_acc got nonzero exp 0"); end
        checks++; if ({out_beats, out_ovf, out_forced} !== '0) begin
            errors++; $display("FAIL reset_flags got beats %0d ovf %0b forced %0b exp 0", out_beats, out_ovf, out_forced);
        end
        in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_single_beat;
        set_all_pc(0); set_all_thr(0);
        pc_flat[0*PCW +: PCW]     = 7'd28;
        thr_flat[0*ACCW +: ACCW]  = 12'd28;
        thr_flat[63*ACCW +: ACCW] = 12'd1;
        out_ready = 1'b1;
        send_beat(1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", out_valid); end
        checks++; if (act_out[0] !== 1'b1) begin errors++; $display("FAIL single_act0 got %0b exp 1", act_out[0]); end
        checks++; if (act_out[63] !== 1'b0) begin errors++; $display("FAIL single_act63 got %0b exp 0", act_out[63]); end
        checks++; if (act_out[30] !== 1'b1) begin errors++; $display("FAIL single_act30_thr0 got %0b exp 1", act_out[30]); end
        checks++; if (lane_acc(0) !== 28) begin errors++; $display("FAIL single_acc0 got %0d exp 28", lane_acc(0)); end
        checks++; if (out_beats !== 7'd1) begin errors++; $display("FAIL single_beats got %0d exp 1", out_beats); end
        checks++; if (out_ovf !== 1'b0 || out_forced !== 1'b0) begin
            errors++; $display("FAIL single_flags got ovf %0b forced %0b exp 0 0", out_ovf, out_forced);
        end
        idle(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b exp 0", out_valid); end
        checks++; if (lane_acc(0) !== 28) begin errors++; $display("FAIL drain_hold_acc0 got %0d exp 28", lane_acc(0)); end
    endtask

    task automatic test_three_beats(input int thr, input logic exp_act);
        set_all_pc(0); set_all_thr(0);
        thr_flat[5*ACCW +: ACCW] = ACCW'(thr);
        out_ready = 1'b1;
        pc_flat[5*PCW +: PCW] = 7'd10; send_beat(1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL three_early_valid got %0b exp 0", out_valid); end
        pc_flat[5*PCW +: PCW] = 7'd20; send_beat(1'b0);
        pc_flat[5*PCW +: PCW] = 7'd30; send_beat(1'b1);
        checks++; if (lane_acc(5) !== 60) begin errors++; $display("FAIL three_acc5 got %0d exp 60", lane_acc(5)); end
        checks++; if (act_out[5] !== exp_act) begin errors++; $display("FAIL three_act5_thr%0d got %0b exp %0b", thr, act_out[5], exp_act); end
        checks++; if (out_beats !== 7'd3) begin errors++; $display("FAIL three_beats got %0d exp 3", out_beats); end
        idle(1);
    endtask

    task automatic test_backpressure;
        set_all_pc(2); set_all_thr(0);
        out_ready = 1'b0;
        send_beat(1'b1);
        checks++; if (out_valid !== 1'b1 || lane_acc(0) !== 2) begin
            errors++; $display("FAIL bp_first got valid %0b acc %0d exp 1 2", out_valid, lane_acc(0));
        end
        set_all_pc(9); in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d] got %0b exp 0", i, in_ready); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || lane_acc(0) !== 2 || out_beats !== 7'd1) begin
                errors++; $display("FAIL bp_stall_hold[%0d] got valid %0b acc %0d beats %0d exp 1 2 1", i, out_valid, lane_acc(0), out_beats);
            end
        end
        set_all_pc(7); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b1 || lane_acc(0) !== 7 || lane_acc(40) !== 7) begin
            errors++; $display("FAIL bp_swap got valid %0b acc0 %0d acc40 %0d exp 1 7 7", out_valid, lane_acc(0), lane_acc(40));
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        set_all_thr(0); out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            set_all_pc(k);
            send_beat(1'b1);
            checks++; if (out_valid !== 1'b1 || lane_acc(17) !== k || out_beats !== 7'd1) begin
                errors++; $display("FAIL b2b[%0d] got valid %0b acc %0d beats %0d exp 1 %0d 1", k, out_valid, lane_acc(17), out_beats, k);
            end
        end
        idle(1);
    endtask

    task automatic test_forced_close;
        set_all_pc(64); set_all_thr(4095); out_ready = 1'b1;
        in_valid = 1'b1; in_last = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL forced_early_valid got %0b exp 0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL forced_valid got %0b exp 1", out_valid); end
        checks++; if (lane_acc(0) !== 4095 || lane_acc(63) !== 4095) begin
            errors++; $display("FAIL forced_acc got %0d %0d exp 4095", lane_acc(0), lane_acc(63));
        end
        checks++; if (out_ovf !== 1'b1 || out_forced !== 1'b1) begin
            errors++; $display("FAIL forced_flags got ovf %0b forced %0b exp 1 1", out_ovf, out_forced);
        end
        checks++; if (out_beats !== 7'd64) begin errors++; $display("FAIL forced_beats got %0d exp 64", out_beats); end
        checks++; if (act_out !== {NP{1'b1}}) begin errors++; $display("FAIL forced_act got %h exp all ones", act_out); end
        set_all_pc(1); set_all_thr(2);
        send_beat(1'b1);
        checks++; if (lane_acc(9) !== 1 || out_beats !== 7'd1 || out_ovf !== 1'b0 || out_forced !== 1'b0) begin
            errors++; $display("FAIL forced_restart got acc %0d beats %0d ovf %0b forced %0b exp 1 1 0 0", lane_acc(9), out_beats, out_ovf, out_forced);
        end
        checks++; if (act_out !== '0) begin errors++; $display("FAIL forced_restart_act got %h exp 0", act_out); end
        idle(1);
    endtask

    task automatic test_reset_mid;
        set_all_pc(40); set_all_thr(0); out_ready = 1'b1;
        send_beat(1'b0);
        send_beat(1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b exp 0", out_valid); end
        set_all_pc(3);
        send_beat(1'b1);
        checks++; if (lane_acc(0) !== 3 || lane_acc(50) !== 3) begin
            errors++; $display("FAIL rmid_acc got %0d %0d exp 3", lane_acc(0), lane_acc(50));
        end
        checks++; if (out_beats !== 7'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_beats got %0d valid %0b exp 1 1", out_beats, out_valid);
        end
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        pc_flat = '0; thr_flat = '0;
        test_reset;
        test_single_beat;
        test_three_beats(61, 1'b0);
        test_three_beats(60, 1'b1);
        test_backpressure;
        test_back_to_back;
        test_forced_close;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
